axis_frame_buffer: RTL and testbench
====================================

// Module: axis_frame_buffer
// PURPOSE
//  Parametrised store-and-forward AXI-Stream frame buffer with replay. On an ex_start handshake it
//  captures one frame from the slave stream into internal RAM. It then plays the frame out on the
//  master stream cfg_replay times, so feature maps and weights can be reused by the CNN datapath.
//  Sits between the DMA stream and the convolution engine.
// PARAMETERS
//  DATA_W  32    stream data width (bits)
//  DEPTH   1024  max words per frame (power of 2, >=4)
//  ADDR_W  $clog2(DEPTH)  RAM address width (derived, do not override)
//  REP_W   8     width of replay count
// PORTS
//  clk           in   1         rising-edge clock
//  rst_n         in   1         asynchronous active-low reset
//  ex_start      in   1         start request (level, four-phase with ex_startAck)
//  ex_startAck   out  1         start acknowledge
//  cfg_replay    in   REP_W     number of playback passes, sampled at start accept; 0 treated as 1
//  s_data        in   DATA_W    slave data
//  s_valid       in   1         slave valid
//  s_last        in   1         slave end-of-frame
//  s_ready       out  1         slave ready
//  m_data        out  DATA_W    master data
//  m_valid       out  1         master valid
//  m_last        out  1         master end-of-pass
//  m_ready       in   1         master ready
//  frame_len     out  ADDR_W+1  words captured in current frame
//  busy          out  1         high in every state except IDLE
//  done          out  1         one-cycle pulse when the final pass completes
//  err_overflow  out  1         sticky: frame truncated at DEPTH; cleared on next start accept
// BEHAVIOUR
//  Reset: every output = 0; FSM -> IDLE; counters = 0. RAM contents undefined and not cleared.
//  FSM states: IDLE, FILL, DRAIN.
//   IDLE->FILL: on ex_start=1. Same edge: latch cfg_replay, clear frame_len and err_overflow,
//    set ex_startAck=1.
//   ex_startAck stays 1 while ex_start=1 and clears the cycle after ex_start is sampled 0,
//    independent of state.
//   FILL: s_ready=1 (registered, first high the cycle after the start accept). Each s_valid&s_ready
//    beat writes RAM[wr_ptr] and increments frame_len.
//   FILL->DRAIN: on a handshake with s_last=1, or on the DEPTH-th word without s_last. In the
//    second case set err_overflow=1 and drop s_ready; extra upstream words stay stalled.
//    s_ready=0 on the cycle after the terminating beat.
//   DRAIN: first m_valid exactly 2 cycles after the terminating slave beat (RAM read latency 1).
//    Sustains 1 beat/cycle while m_ready=1 (one-entry prefetch/skid register).
//    While m_valid=1 and m_ready=0, m_data/m_last hold stable. m_valid never drops without
//    a handshake.
//   m_last=1 on word frame_len-1 of every pass; read pointer wraps to 0 for the next pass, with no
//    bubble between passes.
//   DRAIN->IDLE: after the m_last handshake of the final pass. done=1 for that one cycle and
//    m_valid=0 the next cycle.
//  Boundaries:
//   ex_start while FILL/DRAIN is ignored (no ack, no restart).
//   1-word frame: s_last on the first beat gives frame_len=1; each pass has m_valid&m_last on
//    that single word.
//   s_last on exactly the DEPTH-th word is a normal end with no overflow.
//   cfg_replay changes after the start accept have no effect.
//   Async reset mid-FILL/DRAIN: immediate return to reset values; the next ex_start starts a
//    fresh frame.
//  Width rules: frame_len is ADDR_W+1 bits so it holds DEPTH. The pass counter is REP_W bits and
//   counts down to 1.
// STRUCTURE
//  Shared package/header: FSM state localparams (IDLE=2'd0, FILL=2'd1, DRAIN=2'd2).
//  One sub-module: sdp_ram. Simple dual-port RAM, 1 write port, 1 registered read port,
//   parameters DATA_W/ADDR_W. Infers BRAM.
//  Top level holds the FSM, pointers, pass counter, prefetch/skid register and start handshake.
// TESTING
//  1. DEPTH=1024, cfg_replay=1. Send 8 words 1..8 with s_valid pulsed on alternate cycles and
//     last on 8; m_ready toggles. -> m_data 1..8 in order, m_last only on 8, frame_len=8,
//     done pulses once.
//  2. cfg_replay=3, 8-word frame, m_ready=1 constantly. -> 24 consecutive beats with no gaps;
//     m_last on beats 8/16/24; first m_valid 2 cycles after s_last.
//  3. DEPTH=16, send 20 words without s_last. -> 16 stored, err_overflow=1, s_ready=0 after
//     word 16, playback 1..16 with m_last on 16.
//  4. Hold m_ready=0 for 5 cycles mid-pass. -> m_valid stays 1; m_data/m_last unchanged until
//     the handshake.
//  5. Assert rst_n=0 during DRAIN. -> all outputs 0 immediately; a new ex_start captures and
//     replays a fresh 4-word frame correctly.
//  6. Raise ex_start during DRAIN. -> no ex_startAck and playback unaffected. 1-word frame:
//     m_last on every beat.

Source files
------------

// File: rtl/axis_frame_buffer_pkg.sv
// Shared types for the AXI-Stream frame buffer: FSM state encoding.
package axis_frame_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
module sdp_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned WORDS = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Read register holds its value when rd_en is low, doubling as the output skid stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axis_frame_buffer.sv
// Store-and-forward AXI-Stream frame buffer: captures one frame, then replays it cfg_replay times.
module axis_frame_buffer
  import axis_frame_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned REP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_start,
  output logic              ex_startAck,
  input  logic [REP_W-1:0]  cfg_replay,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic [ADDR_W:0]   frame_len,
  output logic              busy,
  output logic              done,
  output logic              err_overflow
);

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

  state_t             state;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [REP_W-1:0]   pass_cnt;
  logic               rd_active;

  logic accept_c, beat_c, full_c, adv_c, issue_c, word_last_c, fin_c;

  always_comb begin
    accept_c    = (state == IDLE) && ex_start;
    beat_c      = (state == FILL) && s_valid && s_ready;
    full_c      = (frame_len == LAST_IDX);
    adv_c       = !m_valid || m_ready;
    issue_c     = (state == DRAIN) && rd_active && adv_c;
    word_last_c = ({1'b0, rd_ptr} == (frame_len - (ADDR_W+1)'(1)));
    fin_c       = (state == DRAIN) && !rd_active && m_valid && m_ready && m_last;
  end

  sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (beat_c),
    .wr_addr (frame_len[ADDR_W-1:0]),
    .wr_data (s_data),
    .rd_en   (issue_c),
    .rd_addr (rd_ptr),
    .rd_data (m_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rd_ptr       <= '0;
      pass_cnt     <= '0;
      rd_active    <= 1'b0;
      ex_startAck  <= 1'b0;
      s_ready      <= 1'b0;
      m_valid      <= 1'b0;
      m_last       <= 1'b0;
      frame_len    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      done        <= 1'b0;
      ex_startAck <= ex_start && (ex_startAck || accept_c);

      // Output stage advances with the RAM read register; holds while stalled.
      if (issue_c) begin
        m_valid <= 1'b1;
        m_last  <= word_last_c;
      end else if (adv_c) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept_c) begin
            state        <= FILL;
            busy         <= 1'b1;
            s_ready      <= 1'b1;
            frame_len    <= '0;
            err_overflow <= 1'b0;
            pass_cnt     <= (cfg_replay == '0) ? REP_W'(1) : cfg_replay;
          end
        end
        FILL: begin
          if (beat_c) begin
            frame_len <= frame_len + (ADDR_W+1)'(1);
            if (s_last || full_c) begin
              state     <= DRAIN;
              s_ready   <= 1'b0;
              rd_ptr    <= '0;
              rd_active <= 1'b1;
              if (full_c && !s_last) err_overflow <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (issue_c) begin
            if (word_last_c) begin
              rd_ptr <= '0;
              if (pass_cnt == REP_W'(1)) rd_active <= 1'b0;
              else                       pass_cnt  <= pass_cnt - REP_W'(1);
            end else begin
              rd_ptr <= rd_ptr + ADDR_W'(1);
            end
          end
          if (fin_c) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_buffer.sv
// Directed self-checking bench: a DEPTH=1024 instance and a DEPTH=16 instance share the stream inputs.
module tb_axis_frame_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_start_b, ex_start_s;
  logic [7:0]  cfg_replay;
  logic [31:0] s_data;
  logic        s_valid, s_last, m_ready;

  logic        ack_b, s_ready_b, m_valid_b, m_last_b, busy_b, done_b, err_b;
  logic [31:0] m_data_b;
  logic [10:0] frame_len_b;
  logic        ack_s, s_ready_s, m_valid_s, m_last_s, busy_s, done_s, err_s;
  logic [31:0] m_data_s;
  logic [4:0]  frame_len_s;

  int n_checks = 0;
  int n_errors = 0;
  int rdy_mode = 0;   // 0: ready high, 1: toggle, 2: ready low
  int done_cnt_b = 0;
  int cyc = 0;

  typedef struct { logic last; logic [31:0] data; int cyc; } beat_t;
  beat_t qb[$];
  beat_t qs[$];

  always #5 clk = ~clk;

  axis_frame_buffer #(.DATA_W(32), .DEPTH(1024), .REP_W(8)) u_big (
    .clk(clk), .rst_n(rst_n), .ex_start(ex_start_b), .ex_startAck(ack_b), .cfg_replay(cfg_replay),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready_b),
    .m_data(m_data_b), .m_valid(m_valid_b), .m_last(m_last_b), .m_ready(m_ready),
    .frame_len(frame_len_b), .busy(busy_b), .done(done_b), .err_overflow(err_b));

  axis_frame_buffer #(.DATA_W(32), .DEPTH(16), .REP_W(8)) u_small (
    .clk(clk), .rst_n(rst_n), .ex_start(ex_start_s), .ex_startAck(ack_s), .cfg_replay(cfg_replay),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready_s),
    .m_data(m_data_s), .m_valid(m_valid_s), .m_last(m_last_s), .m_ready(m_ready),
    .frame_len(frame_len_s), .busy(busy_s), .done(done_s), .err_overflow(err_s));

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) m_ready = ~m_ready;
    else               m_ready = (rdy_mode == 0);
  end

  always @(negedge clk) begin
    cyc++;
    if (m_valid_b && m_ready) qb.push_back('{m_last_b, m_data_b, cyc});
    if (m_valid_s && m_ready) qs.push_back('{m_last_s, m_data_s, cyc});
    if (done_b) done_cnt_b++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input bit sel, input logic [7:0] r);
    bit found = 0;
    @(posedge clk); #1;
    cfg_replay = r;
    if (sel) ex_start_s = 1'b1; else ex_start_b = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sel ? ack_s : ack_b) begin found = 1; break; end
    end
    chk("start_ack_seen", 64'(found), 64'(1));
    chk("s_ready_after_accept", 64'(sel ? s_ready_s : s_ready_b), 64'(1));
    chk("busy_after_accept", 64'(sel ? busy_s : busy_b), 64'(1));
    chk("frame_len_cleared", 64'(sel ? 11'(frame_len_s) : frame_len_b), 64'(0));
    chk("err_cleared", 64'(sel ? err_s : err_b), 64'(0));
    @(posedge clk); #1;
    if (sel) ex_start_s = 1'b0; else ex_start_b = 1'b0;
    @(negedge clk);
    chk("ack_hold", 64'(sel ? ack_s : ack_b), 64'(1));
    @(negedge clk);
    chk("ack_release", 64'(sel ? ack_s : ack_b), 64'(0));
  endtask

  // Drives one word and returns just after the edge that accepts it.
  task automatic send_word(input logic [31:0] d, input logic l);
    bit found = 0;
    s_data = d; s_valid = 1'b1; s_last = l;
    for (int i = 0; i < 64; i++) begin
      if (s_ready_b || s_ready_s) begin found = 1; break; end
      @(negedge clk);
    end
    if (!found) chk($sformatf("s_hs_timeout_%0h", d), 64'(found), 64'(1));
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_done(input bit sel);
    bit found = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sel ? done_s : done_b) begin found = 1; break; end
    end
    chk("done_seen", 64'(found), 64'(1));
    @(negedge clk);
    chk("done_one_cycle", 64'(sel ? done_s : done_b), 64'(0));
    chk("m_valid_after_done", 64'(sel ? m_valid_s : m_valid_b), 64'(0));
    chk("busy_after_done", 64'(sel ? busy_s : busy_b), 64'(0));
  endtask

  initial begin
    int gaps;
    logic [31:0] hd;
    logic        hl;
    bit          found;
    rst_n = 1'b0; ex_start_b = 0; ex_start_s = 0; cfg_replay = 0;
    s_data = 0; s_valid = 0; s_last = 0; m_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 64'(ack_b), 64'(0));
    chk("rst_outs_big", 64'({s_ready_b, m_valid_b, m_last_b, busy_b, done_b, err_b}), 64'(0));
    chk("rst_mdata", 64'(m_data_b), 64'(0));
    chk("rst_len", 64'(frame_len_b), 64'(0));
    chk("rst_outs_small", 64'({ack_s, s_ready_s, m_valid_s, busy_s, err_s, frame_len_s}), 64'(0));
    @(posedge clk); #1; rst_n = 1'b1;

    // Test 1: alternate-cycle input, toggling m_ready, one pass
    rdy_mode = 1;
    do_start(0, 8'd1);
    for (int i = 0; i < 8; i++) begin
      send_word(32'(i + 1), i == 7);
      @(posedge clk); #1;
    end
    wait_done(0);
    chk("t1_beats", 64'(qb.size()), 64'(8));
    for (int i = 0; i < qb.size() && i < 8; i++) begin
      chk($sformatf("t1_data%0d", i), 64'(qb[i].data), 64'(i + 1));
      chk($sformatf("t1_last%0d", i), 64'(qb[i].last), 64'(i == 7));
    end
    chk("t1_frame_len", 64'(frame_len_b), 64'(8));
    chk("t1_done_count", 64'(done_cnt_b), 64'(1));
    chk("t1_no_overflow", 64'(err_b), 64'(0));

    // Test 2: three passes, m_ready high, cfg_replay changed after accept
    rdy_mode = 0; qb.delete();
    do_start(0, 8'd3);
    cfg_replay = 8'd7;
    for (int i = 0; i < 8; i++) send_word(32'h100 + 32'(i), i == 7);
    @(negedge clk);
    chk("t2_lat_k1_valid", 64'(m_valid_b), 64'(0));
    chk("t2_s_ready_drop", 64'(s_ready_b), 64'(0));
    @(negedge clk);
    chk("t2_lat_k2_valid", 64'(m_valid_b), 64'(1));
    chk("t2_lat_k2_data", 64'(m_data_b), 64'h100);
    wait_done(0);
    chk("t2_beats", 64'(qb.size()), 64'(24));
    gaps = 0;
    for (int i = 0; i < qb.size() && i < 24; i++) begin
      chk($sformatf("t2_data%0d", i), 64'(qb[i].data), 64'(32'h100 + 32'(i % 8)));
      chk($sformatf("t2_last%0d", i), 64'(qb[i].last), 64'((i % 8) == 7));
      if (i > 0 && qb[i].cyc != qb[i-1].cyc + 1) gaps++;
    end
    chk("t2_gaps", 64'(gaps), 64'(0));
    chk("t2_frame_len", 64'(frame_len_b), 64'(8));

    // Test 3: overflow on the DEPTH=16 instance, cfg_replay=0 means one pass
    qs.delete();
    do_start(1, 8'd0);
    for (int i = 0; i < 16; i++) send_word(32'h300 + 32'(i), 1'b0);
    s_data = 32'h310; s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t3_stall%0d", i), 64'(s_ready_s), 64'(0));
    end
    chk("t3_overflow", 64'(err_s), 64'(1));
    chk("t3_frame_len", 64'(frame_len_s), 64'(16));
    s_valid = 1'b0;
    wait_done(1);
    chk("t3_beats", 64'(qs.size()), 64'(16));
    for (int i = 0; i < qs.size() && i < 16; i++) begin
      chk($sformatf("t3_data%0d", i), 64'(qs[i].data), 64'(32'h300 + 32'(i)));
      chk($sformatf("t3_last%0d", i), 64'(qs[i].last), 64'(i == 15));
    end
    chk("t3_err_sticky", 64'(err_s), 64'(1));

    // Test 4: m_ready low for 5 cycles mid-pass
    rdy_mode = 0; qb.delete();
    do_start(0, 8'd1);
    for (int i = 0; i < 8; i++) send_word(32'h200 + 32'(i), i == 7);
    found = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (qb.size() >= 3) begin found = 1; break; end
    end
    chk("t4_reach_mid", 64'(found), 64'(1));
    rdy_mode = 2;
    @(negedge clk);
    hd = 32'h200 + 32'(qb.size());
    hl = (qb.size() == 7);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t4_valid%0d", i), 64'(m_valid_b), 64'(1));
      chk($sformatf("t4_data%0d", i), 64'(m_data_b), 64'(hd));
      chk($sformatf("t4_last%0d", i), 64'(m_last_b), 64'(hl));
      @(negedge clk);
    end
    rdy_mode = 0;
    wait_done(0);
    chk("t4_beats", 64'(qb.size()), 64'(8));
    for (int i = 0; i < qb.size() && i < 8; i++)
      chk($sformatf("t4_order%0d", i), 64'({qb[i].last, qb[i].data}), 64'({i == 7, 32'h200 + 32'(i)}));

    // Test 5: async reset during DRAIN, then a fresh 4-word frame with two passes
    rdy_mode = 2;
    do_start(0, 8'd1);
    for (int i = 0; i < 8; i++) send_word(32'h400 + 32'(i), i == 7);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_valid_b) begin found = 1; break; end
    end
    chk("t5_in_drain", 64'(found), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_flags", 64'({ack_b, s_ready_b, m_valid_b, m_last_b, busy_b, done_b, err_b}), 64'(0));
    chk("t5_rst_mdata", 64'(m_data_b), 64'(0));
    chk("t5_rst_len", 64'(frame_len_b), 64'(0));
    @(posedge clk); #1; rst_n = 1'b1;
    rdy_mode = 0; qb.delete();
    do_start(0, 8'd2);
    for (int i = 0; i < 4; i++) send_word(32'h500 + 32'(i), i == 3);
    wait_done(0);
    chk("t5_beats", 64'(qb.size()), 64'(8));
    for (int i = 0; i < qb.size() && i < 8; i++)
      chk($sformatf("t5_beat%0d", i), 64'({qb[i].last, qb[i].data}), 64'({(i % 4) == 3, 32'h500 + 32'(i % 4)}));
    chk("t5_frame_len", 64'(frame_len_b), 64'(4));

    // Test 6: ex_start during DRAIN is ignored; 1-word frame, three passes
    rdy_mode = 2; qb.delete();
    do_start(0, 8'd3);
    send_word(32'h600, 1'b1);
    ex_start_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t6_no_ack%0d", i), 64'(ack_b), 64'(0));
      chk($sformatf("t6_busy%0d", i), 64'(busy_b), 64'(1));
    end
    ex_start_b = 1'b0;
    rdy_mode = 0;
    wait_done(0);
    chk("t6_frame_len", 64'(frame_len_b), 64'(1));
    chk("t6_beats", 64'(qb.size()), 64'(3));
    for (int i = 0; i < qb.size() && i < 3; i++)
      chk($sformatf("t6_beat%0d", i), 64'({qb[i].last, qb[i].data}), 64'({1'b1, 32'h600}));
    chk("t6_idle_ack", 64'(ack_b), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
